// File: rtl/regfile_writeback_if.sv
// Write-back, issue and operand-read signals between the pipeline and the register file.
// The pipeline side takes the master modport, the register file takes the slave modport.
interface regfile_writeback_if #(
  parameter int W = 32
);
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [W-1:0] wb_data;
  logic         issue_en;
  logic [4:0]   issue_dst;
  logic         hold;
  logic [4:0]   raddr_a;
  logic [4:0]   raddr_b;
  logic [W-1:0] rdata_a;
  logic [W-1:0] rdata_b;
  logic         busy_a;
  logic         busy_b;

  modport master (
    output wb_en, wb_addr, wb_data, issue_en, issue_dst, hold, raddr_a, raddr_b,
    input  rdata_a, rdata_b, busy_a, busy_b
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, issue_en, issue_dst, hold, raddr_a, raddr_b,
    output rdata_a, rdata_b, busy_a, busy_b
  );
endinterface

// File: rtl/regfile_writeback.sv
// 32-entry register file: one write-back port, two registered read ports, and a pending-write scoreboard.
// Optional REGFILE_BYPASS_EN forwards same-edge write-back data and masks busy on a matching read.
module regfile_writeback #(
  parameter int W      = 32,
  parameter int N_REGS = 32
) (
  input logic                 clock,
  input logic                 reset,
  regfile_writeback_if.slave  bus
);
  localparam int NP = 2;

  logic [N_REGS-1:0][W-1:0] regs_q;
  logic [N_REGS-1:0]        busy_q, busy_d;
  logic [NP-1:0][4:0]       raddr;
  logic [NP-1:0][W-1:0]     rdata_q, rdata_d;
  logic [NP-1:0]            busy_rd;
  logic                     wr_ok, iss_ok;

  assign wr_ok  = bus.wb_en    && (bus.wb_addr   != 5'd0);
  assign iss_ok = bus.issue_en && (bus.issue_dst != 5'd0);
  assign raddr  = {bus.raddr_b, bus.raddr_a};

  // Issue is applied after write-back so a same-edge issue leaves the register pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[bus.wb_addr]   = 1'b0;
    if (iss_ok) busy_d[bus.issue_dst] = 1'b1;
  end

  // regs_q[0] is cleared by reset and never written, so it reads as zero without a mux.
  for (genvar p = 0; p < NP; p++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit        = wr_ok && (bus.wb_addr == raddr[p]);
    assign rdata_d[p] = bus.hold ? rdata_q[p] :
                        hit      ? bus.wb_data : regs_q[raddr[p]];
    assign busy_rd[p] = busy_q[raddr[p]] && !hit;
`else
    assign rdata_d[p] = bus.hold ? rdata_q[p] : regs_q[raddr[p]];
    assign busy_rd[p] = busy_q[raddr[p]];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q  <= '0;
      busy_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_ok) regs_q[bus.wb_addr] <= bus.wb_data;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.rdata_a = rdata_q[0];
  assign bus.rdata_b = rdata_q[1];
  assign bus.busy_a  = busy_rd[0];
  assign bus.busy_b  = busy_rd[1];
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a reference model queues expected read data each cycle.
// Directed cases, then a random phase.
module tb_regfile_writeback;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_writeback_if #(.W(W)) bus ();
  regfile_writeback #(.W(W), .N_REGS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [W-1:0] m_regs [32];
  logic         m_busy [32];
  logic [W-1:0] m_ra, m_rb;
  exp_t         sb_q [$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_rd(input logic [4:0] a);
    if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic m_bsy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_ra = '0;
    m_rb = '0;
    sb_q.delete();
  endtask

  task automatic idle();
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.issue_en  = 1'b0;
    bus.issue_dst = '0;
    bus.hold      = 1'b0;
  endtask

  // Inputs are set before the call; checks busy, queues expected read data, clocks, compares.
  task automatic cyc();
    exp_t e;
    #1;
    chk("busy_a", {31'd0, bus.busy_a}, {31'd0, m_bsy(bus.raddr_a)});
    chk("busy_b", {31'd0, bus.busy_b}, {31'd0, m_bsy(bus.raddr_b)});
    e.a = bus.hold ? m_ra : m_rd(bus.raddr_a);
    e.b = bus.hold ? m_rb : m_rd(bus.raddr_b);
    sb_q.push_back(e);
    if (bus.wb_en && bus.wb_addr != 5'd0) begin
      m_regs[bus.wb_addr] = bus.wb_data;
      m_busy[bus.wb_addr] = 1'b0;
    end
    if (bus.issue_en && bus.issue_dst != 5'd0) m_busy[bus.issue_dst] = 1'b1;
    m_ra = e.a;
    m_rb = e.b;
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("rdata_a", bus.rdata_a, e.a);
      chk("rdata_b", bus.rdata_b, e.b);
    end
  endtask

  task automatic wb(input logic [4:0] a, input logic [W-1:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_addr = a;
    bus.wb_data = d;
  endtask

  initial begin
    idle();
    bus.raddr_a = '0;
    bus.raddr_b = '0;
    reset = 1'b1;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_rdata_a", bus.rdata_a, '0);
    chk("rst_rdata_b", bus.rdata_b, '0);
    reset = 1'b0;

    // reset mid-operation discards data, busy bits and outputs
    wb(5'd5, 32'hDEADBEEF); cyc();
    idle(); bus.raddr_a = 5'd5; bus.issue_en = 1'b1; bus.issue_dst = 5'd6; cyc();
    chk("pre_rst_r5", bus.rdata_a, 32'hDEADBEEF);
    idle(); bus.raddr_a = 5'd6;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_rdata_a", bus.rdata_a, '0);
    chk("async_rst_busy_a", {31'd0, bus.busy_a}, '0);
    m_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    bus.raddr_a = 5'd5; cyc();
    chk("post_rst_r5", bus.rdata_a, '0);

    // register 0 ignores writes and issues
    wb(5'd0, 32'h12345678); bus.issue_en = 1'b1; bus.issue_dst = 5'd0;
    bus.raddr_a = 5'd0; bus.raddr_b = 5'd0; cyc();
    idle(); cyc();
    chk("r0_a", bus.rdata_a, '0);
    chk("r0_b", bus.rdata_b, '0);
    chk("r0_busy", {31'd0, bus.busy_a}, '0);

    // basic write then read on both ports
    wb(5'd3, 32'hA5A5A5A5); cyc();
    wb(5'd7, 32'h0000FFFF); cyc();
    idle(); bus.raddr_a = 5'd3; bus.raddr_b = 5'd7; cyc();
    chk("basic_a", bus.rdata_a, 32'hA5A5A5A5);
    chk("basic_b", bus.rdata_b, 32'h0000FFFF);

    // scoreboard: issue, issue+wb same edge, lone wb
    bus.raddr_a = 5'd9; bus.issue_en = 1'b1; bus.issue_dst = 5'd9; cyc();
    chk("sb_set", {31'd0, bus.busy_a}, 32'd1);
    wb(5'd9, 32'h99); cyc();
    chk("sb_issue_wins", {31'd0, bus.busy_a}, 32'd1);
    idle(); wb(5'd9, 32'h98); cyc();
    idle(); #1;
    chk("sb_clear", {31'd0, bus.busy_a}, '0);

    // same-edge write/read collision
    wb(5'd4, 32'h11); cyc();
    wb(5'd4, 32'h22); bus.raddr_a = 5'd4; cyc();
`ifdef REGFILE_BYPASS_EN
    chk("collide", bus.rdata_a, 32'h22);
`else
    chk("collide", bus.rdata_a, 32'h11);
`endif
    idle(); cyc();
    chk("collide_next", bus.rdata_a, 32'h22);

    // hold freezes outputs but not writes
    bus.hold = 1'b1; bus.raddr_a = 5'd3; wb(5'd4, 32'h33); cyc();
    chk("hold_keep", bus.rdata_a, 32'h22);
    idle(); cyc();
    chk("hold_release", bus.rdata_a, 32'hA5A5A5A5);
    bus.raddr_a = 5'd4; cyc();
    chk("hold_wr", bus.rdata_a, 32'h33);

    // random traffic against the model
    for (int i = 0; i < 300; i++) begin
      bus.wb_en     = ($urandom_range(0, 1) == 1);
      bus.wb_addr   = 5'($urandom_range(0, 31));
      bus.wb_data   = $urandom;
      bus.issue_en  = ($urandom_range(0, 2) == 0);
      bus.issue_dst = 5'($urandom_range(0, 31));
      bus.hold      = ($urandom_range(0, 4) == 0);
      bus.raddr_a   = ($urandom_range(0, 2) == 0) ? bus.wb_addr : 5'($urandom_range(0, 31));
      bus.raddr_b   = 5'($urandom_range(0, 31));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
